fir_frame_buffer: RTL and testbench
===================================

Name: fir_frame_buffer

Overview:
- Serial-to-parallel receiver on the FIR output stream. It consumes fir_d/fir_valid and assembles consecutive samples into N-sample frames for the FFT stage.
- Uses two ping-pong register banks so the FIR stream never stalls. The FIR side has no back-pressure.
- Presents each complete frame on a wide parallel bus with a valid/ready handshake.

Parameters:
- DW, 16, sample width (signed two's complement)
- N, 16, samples per frame; power of two, at least 2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- fir_d  in  DW  signed FIR output sample
- fir_valid  in  1  qualifies fir_d; one sample per cycle while high
- fft_ready  in  1  FFT accepts the presented frame
- fft_valid  out  1  a complete frame is presented on fft_data
- fft_data  out  N*DW  frame; oldest sample in [DW-1:0], newest in [N*DW-1:(N-1)*DW]
- overrun  out  1  sticky flag: a sample was dropped because no bank was free

Behaviour:
- Reset (rst low, asynchronous):
  - Write pointer wcnt=0; wbank=0; rbank=0.
  - Both banks EMPTY; bank contents cleared to 0.
  - fft_valid=0, fft_data=0, overrun=0.
- Bank states: EMPTY -> FILLING -> FULL -> EMPTY.
  - FILLING is entered on the first sample written to a bank.
  - FULL is entered on the Nth sample.
  - EMPTY is re-entered on the handshake (fft_valid && fft_ready) for that bank.
- Write side, per cycle with fir_valid=1 and bank[wbank] not FULL:
  - bank[wbank][wcnt] <= fir_d; wcnt increments.
  - When wcnt==N-1: bank[wbank] becomes FULL, wbank toggles, wcnt wraps to 0.
- Overrun: fir_valid=1 while bank[wbank] is FULL.
  - Sample is dropped; wcnt and wbank are unchanged.
  - overrun is set and stays set until reset.
- Read side, 2-state FSM:
  - IDLE: fft_valid=0. If bank[rbank] is FULL, go to PRESENT next cycle.
  - PRESENT: fft_valid=1 and fft_data = bank[rbank], both stable until handshake.
  - On handshake: bank[rbank] becomes EMPTY, rbank toggles. Go back to IDLE, or stay in PRESENT if the other bank is already FULL, so frames go out back-to-back.
- Latency: fft_valid rises exactly 1 cycle after the clock edge that writes the Nth sample, provided the read FSM is IDLE.
- fft_data is driven from the bank registers selected by rbank. It must not change while fft_valid=1 and fft_ready=0.
- Simultaneous events:
  - When the handshake frees bank X in the same cycle a write targets bank X, the write is accepted; the free is visible to the write side combinationally.
  - A write of the Nth sample into bank X and a handshake on bank Y (X≠Y) in the same cycle are both honoured. Bank X becomes FULL and is presented next cycle.
- fir_valid=0 for any number of cycles: wcnt holds; a partial frame stays FILLING indefinitely.
- No arithmetic is performed; samples pass bit-exact with no saturation or rounding.

Decomposition:
- Shared package fas_pkg holds:
  - DW and N localparams
  - log2(N) pointer width
  - bank-state enum {EMPTY, FILLING, FULL}
  - read-FSM enum {IDLE, PRESENT}
- One sub-module, frame_bank: N x DW register array with write enable, write index and a full parallel read bus. It is instantiated twice. Bank-state tracking, pointers, the read FSM and overrun logic stay in the top module.

Test Plan:
- Reset then 16 cycles of fir_valid=1, fir_d=1..16, fft_ready=1 -> fft_valid=1 for exactly one cycle, 1 cycle after sample 16; fft_data[15:0]=1, fft_data[255:240]=16; overrun=0.
- 32 continuous samples 0x8000..0x801F, fft_ready held 0 until cycle 40 -> frame 0 (0x8000..0x800F) held stable; after handshake, frame 1 (0x8010..0x801F) is presented back-to-back with fft_valid staying high; overrun=0.
- 48 continuous samples with fft_ready=0 throughout -> samples 33..48 dropped, overrun=1 from the 33rd sample on; on release, the two frames come out in order with sample values 1..32.
- Gapped input: fir_valid toggling 1/0, 16 valid samples of -1 (0xFFFF) -> one frame of all 0xFFFF, fft_valid 1 cycle after the 16th valid sample; gap cycles do not advance wcnt.
- Handshake and the first write into the freed bank in the same cycle (both banks full, fft_ready=1) -> write accepted, no overrun, next frame data correct.
- rst pulled low mid-frame after 7 samples, including between clock edges -> all outputs 0 immediately; after release, 16 new samples form a clean frame with no residue of the old 7.

Source files
------------

// File: rtl/fas_pkg.sv
// Shared sizes and state encodings for the FIR-to-FFT frame buffer.
package fas_pkg;

  localparam int DW = 16;
  localparam int N  = 16;
  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } bank_state_e;

  typedef enum logic {
    IDLE,
    PRESENT
  } rd_state_e;

endpackage

// File: rtl/frame_bank.sv
// N x DW sample register bank: one indexed write port, whole bank visible in parallel.
// Write lands on the rising edge; the read bus is the raw register contents.
module frame_bank #(
  parameter int  DW = 16,
  parameter int  N  = 16,
  localparam int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_idx_i,
  input  logic [DW-1:0] wr_dat_i,
  output logic [N*DW-1:0] rd_dat_o
);

  for (genvar i = 0; i < N; i++) begin : g_word
    logic [DW-1:0] word_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        word_q <= '0;
      end else if (wr_en_i && (wr_idx_i == AW'(i))) begin
        word_q <= wr_dat_i;
      end
    end

    assign rd_dat_o[i*DW +: DW] = word_q;
  end

endmodule

// File: rtl/fir_frame_buffer.sv
// Packs the FIR sample stream into N-sample frames via ping-pong banks; fft_valid rises one
// cycle after the Nth sample when idle. FIR side never stalls: samples arriving with no free bank are dropped.
module fir_frame_buffer #(
  parameter int DW = fas_pkg::DW,
  parameter int N  = fas_pkg::N
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   fir_d,
  input  logic            fir_valid,
  input  logic            fft_ready,
  output logic            fft_valid,
  output logic [N*DW-1:0] fft_data,
  output logic            overrun
);

  import fas_pkg::*;

  localparam int AW = $clog2(N);

  bank_state_e     bank_st_q [2];
  bank_state_e     bank_st_d [2];
  rd_state_e       rd_st_q, rd_st_d;
  logic [AW-1:0]   wcnt_q, wcnt_d;
  logic            wbank_q, wbank_d;
  logic            rbank_q, rbank_d;
  logic            ovr_q, ovr_d;

  logic [N*DW-1:0] bank_dat [2];
  logic [1:0]      bank_we;
  logic            handshake;
  logic            wbank_full;
  logic            wr_en;

  assign fft_valid = (rd_st_q == PRESENT);
  assign handshake = fft_valid && fft_ready;

  // A bank released by this cycle's handshake is immediately writable.
  assign wbank_full = (bank_st_q[wbank_q] == FULL) && !(handshake && (rbank_q == wbank_q));
  assign wr_en      = fir_valid && !wbank_full;
  assign bank_we    = {wr_en && wbank_q, wr_en && !wbank_q};

  always_comb begin
    wcnt_d    = wcnt_q;
    wbank_d   = wbank_q;
    ovr_d     = ovr_q | (fir_valid && wbank_full);
    bank_st_d = bank_st_q;

    if (handshake) begin
      bank_st_d[rbank_q] = EMPTY;
    end

    if (wr_en) begin
      if (wcnt_q == AW'(N - 1)) begin
        bank_st_d[wbank_q] = FULL;
        wcnt_d             = '0;
        wbank_d            = ~wbank_q;
      end else begin
        bank_st_d[wbank_q] = FILLING;
        wcnt_d             = wcnt_q + 1'b1;
      end
    end
  end

  // Stay in PRESENT using next-cycle bank state so a frame completing during the handshake goes out back-to-back.
  always_comb begin
    rd_st_d = rd_st_q;
    rbank_d = rbank_q;

    case (rd_st_q)
      IDLE: begin
        if (bank_st_q[rbank_q] == FULL) begin
          rd_st_d = PRESENT;
        end
      end
      PRESENT: begin
        if (handshake) begin
          rbank_d = ~rbank_q;
          rd_st_d = (bank_st_d[~rbank_q] == FULL) ? PRESENT : IDLE;
        end
      end
      default: rd_st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q       <= '0;
      wbank_q      <= 1'b0;
      rbank_q      <= 1'b0;
      ovr_q        <= 1'b0;
      rd_st_q      <= IDLE;
      bank_st_q[0] <= EMPTY;
      bank_st_q[1] <= EMPTY;
    end else begin
      wcnt_q    <= wcnt_d;
      wbank_q   <= wbank_d;
      rbank_q   <= rbank_d;
      ovr_q     <= ovr_d;
      rd_st_q   <= rd_st_d;
      bank_st_q <= bank_st_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_bank #(
      .DW(DW),
      .N (N)
    ) u_bank (
      .clk_i   (clk),
      .rst_ni  (rst),
      .wr_en_i (bank_we[b]),
      .wr_idx_i(wcnt_q),
      .wr_dat_i(fir_d),
      .rd_dat_o(bank_dat[b])
    );
  end

  assign fft_data = rbank_q ? bank_dat[1] : bank_dat[0];
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_fir_frame_buffer.sv
// Bench for fir_frame_buffer: directed scenarios plus random traffic against a frame-queue model.
module tb_fir_frame_buffer;

  localparam int DW = 16;
  localparam int N  = 16;
  localparam int FW = N * DW;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic [DW-1:0] fir_d     = '0;
  logic          fir_valid = 1'b0;
  logic          fft_ready = 1'b0;
  logic          fft_valid;
  logic [FW-1:0] fft_data;
  logic          overrun;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: completed frames waiting for the FFT, the frame being assembled, presentation flag.
  logic [FW-1:0] m_q[$];
  logic [FW-1:0] m_part;
  int            m_cnt;
  bit            m_present;
  bit            m_ovr;

  fir_frame_buffer #(
    .DW(DW),
    .N (N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fir_d    (fir_d),
    .fir_valid(fir_valid),
    .fft_ready(fft_ready),
    .fft_valid(fft_valid),
    .fft_data (fft_data),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] m_front();
    return (m_q.size() > 0) ? m_q[0] : '0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_part    = '0;
    m_cnt     = 0;
    m_present = 1'b0;
    m_ovr     = 1'b0;
  endtask

  // Two frame slots exist; a sample is accepted while fewer than two frames wait, or one leaves this cycle.
  task automatic model_edge();
    bit hs, acc, had;
    hs  = m_present && fft_ready;
    acc = fir_valid && ((m_q.size() < 2) || hs);
    had = (m_q.size() > 0);
    if (fir_valid && !acc) m_ovr = 1'b1;
    if (hs) void'(m_q.pop_front());
    if (acc) begin
      m_part[m_cnt*DW +: DW] = fir_d;
      m_cnt++;
      if (m_cnt == N) begin
        m_q.push_back(m_part);
        m_cnt = 0;
      end
    end
    if (m_present) m_present = hs ? (m_q.size() > 0) : 1'b1;
    else           m_present = had;
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit r);
    fir_valid = v;
    fir_d     = d;
    fft_ready = r;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    #1 rst = 1'b0;
    #2;
    n_checks++;
    if (fft_valid !== 1'b0 || overrun !== 1'b0 || fft_data !== '0)
      $display("FAIL reset valid=%b ovr=%b data=%h required all zero", fft_valid, overrun, fft_data);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_frame();
    int first = -1;
    int nv    = 0;
    logic [FW-1:0] got = '0;
    for (int c = 0; c < 24; c++) begin
      drive(c < 16, DW'(c + 1), 1'b1);
      n_checks++;
      if (fft_valid !== m_present || overrun !== m_ovr || (m_present && fft_data !== m_front()))
        $display("FAIL single c%0d valid=%b/%b ovr=%b/%b data=%h exp %h", c, fft_valid, m_present, overrun, m_ovr, fft_data, m_front());
      else n_pass++;
      if (fft_valid === 1'b1) begin
        if (first < 0) first = c;
        nv++;
        got = fft_data;
      end
      step();
    end
    n_checks++;
    if (first != 17 || nv != 1)
      $display("FAIL single_latency first_valid_cycle=%0d cycles_high=%0d required 17 and 1", first, nv);
    else n_pass++;
    n_checks++;
    if (got[DW-1:0] !== 16'd1 || got[FW-1 -: DW] !== 16'd16)
      $display("FAIL single_order oldest=%h newest=%h required 0001 and 0010", got[DW-1:0], got[FW-1 -: DW]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] outs[$];
    logic [FW-1:0] f0, f1;
    int nf;
    for (int c = 0; c < 80; c++) begin
      drive(c < 32, 16'h8000 + DW'(c), c >= 40);
      n_checks++;
      if (fft_valid !== m_present || overrun !== m_ovr || (m_present && fft_data !== m_front()))
        $display("FAIL b2b c%0d valid=%b/%b ovr=%b/%b data=%h exp %h", c, fft_valid, m_present, overrun, m_ovr, fft_data, m_front());
      else n_pass++;
      if (c == 41) begin
        n_checks++;
        if (fft_valid !== 1'b1 || fft_data[DW-1:0] !== 16'h8010)
          $display("FAIL b2b_next valid=%b oldest=%h required 1 and 8010", fft_valid, fft_data[DW-1:0]);
        else n_pass++;
      end
      if (fft_valid === 1'b1 && fft_ready) outs.push_back(fft_data);
      step();
    end
    nf = outs.size();
    while (outs.size() < 2) outs.push_back('0);
    f0 = outs[0];
    f1 = outs[1];
    n_checks++;
    if (nf != 2 || f0[DW-1:0] !== 16'h8000 || f0[FW-1 -: DW] !== 16'h800F ||
        f1[DW-1:0] !== 16'h8010 || f1[FW-1 -: DW] !== 16'h801F)
      $display("FAIL b2b_frames count=%0d f0=%h..%h f1=%h..%h required 2 8000..800F 8010..801F",
               nf, f0[DW-1:0], f0[FW-1 -: DW], f1[DW-1:0], f1[FW-1 -: DW]);
    else n_pass++;
  endtask

  task automatic test_overrun();
    logic [FW-1:0] outs[$];
    logic [FW-1:0] f0, f1;
    int nf;
    for (int c = 0; c < 100; c++) begin
      drive(c < 48, DW'(c + 1), c >= 60);
      n_checks++;
      if (fft_valid !== m_present || overrun !== m_ovr || (m_present && fft_data !== m_front()))
        $display("FAIL ovr c%0d valid=%b/%b ovr=%b/%b data=%h exp %h", c, fft_valid, m_present, overrun, m_ovr, fft_data, m_front());
      else n_pass++;
      if (c == 32 || c == 33) begin
        n_checks++;
        if (overrun !== (c == 33))
          $display("FAIL ovr_flag c%0d overrun=%b required %b", c, overrun, c == 33);
        else n_pass++;
      end
      if (fft_valid === 1'b1 && fft_ready) outs.push_back(fft_data);
      step();
    end
    nf = outs.size();
    while (outs.size() < 2) outs.push_back('0);
    f0 = outs[0];
    f1 = outs[1];
    n_checks++;
    if (nf != 2 || f0[DW-1:0] !== 16'd1 || f0[FW-1 -: DW] !== 16'd16 ||
        f1[DW-1:0] !== 16'd17 || f1[FW-1 -: DW] !== 16'd32 || overrun !== 1'b1)
      $display("FAIL ovr_frames count=%0d f0=%h..%h f1=%h..%h ovr=%b required 2 1..16 17..32 ovr 1",
               nf, f0[DW-1:0], f0[FW-1 -: DW], f1[DW-1:0], f1[FW-1 -: DW], overrun);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [FW-1:0] outs[$];
    logic [FW-1:0] exp_f;
    int nf;
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, 16'h0A00 + DW'(c), 1'b0);
      n_checks++;
      if (fft_valid !== m_present || overrun !== m_ovr || (m_present && fft_data !== m_front()))
        $display("FAIL midrst c%0d valid=%b/%b ovr=%b/%b data=%h exp %h", c, fft_valid, m_present, overrun, m_ovr, fft_data, m_front());
      else n_pass++;
      step();
    end
    drive(1'b0, '0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (fft_valid !== 1'b0 || overrun !== 1'b0 || fft_data !== '0)
      $display("FAIL midrst_async valid=%b ovr=%b data=%h required all zero", fft_valid, overrun, fft_data);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 30; c++) begin
      drive(c < 16, 16'h5000 + DW'(c), 1'b1);
      n_checks++;
      if (fft_valid !== m_present || overrun !== m_ovr || (m_present && fft_data !== m_front()))
        $display("FAIL midrst_after c%0d valid=%b/%b ovr=%b/%b data=%h exp %h", c, fft_valid, m_present, overrun, m_ovr, fft_data, m_front());
      else n_pass++;
      if (fft_valid === 1'b1 && fft_ready) outs.push_back(fft_data);
      step();
    end
    for (int i = 0; i < N; i++) exp_f[i*DW +: DW] = 16'h5000 + DW'(i);
    nf = outs.size();
    while (outs.size() < 1) outs.push_back('0);
    n_checks++;
    if (nf != 1 || outs[0] !== exp_f)
      $display("FAIL midrst_frame count=%0d got=%h required 1 frame %h", nf, outs[0], exp_f);
    else n_pass++;
  endtask

  task automatic test_gapped();
    int first = -1;
    logic [FW-1:0] got = '0;
    for (int c = 0; c < 46; c++) begin
      drive((c < 32) && (c % 2 == 0), 16'hFFFF, 1'b1);
      n_checks++;
      if (fft_valid !== m_present || overrun !== m_ovr || (m_present && fft_data !== m_front()))
        $display("FAIL gap c%0d valid=%b/%b ovr=%b/%b data=%h exp %h", c, fft_valid, m_present, overrun, m_ovr, fft_data, m_front());
      else n_pass++;
      if (fft_valid === 1'b1 && first < 0) begin
        first = c;
        got   = fft_data;
      end
      step();
    end
    n_checks++;
    if (first != 32 || got !== {FW{1'b1}})
      $display("FAIL gap_frame first_valid_cycle=%0d data=%h required 32 and all ones", first, got);
    else n_pass++;
  endtask

  task automatic test_simul_free();
    logic [FW-1:0] outs[$];
    logic [FW-1:0] f2;
    int nf;
    for (int c = 0; c < 70; c++) begin
      drive(c < 48, 16'h3000 + DW'(c), (c == 32) || (c >= 50));
      n_checks++;
      if (fft_valid !== m_present || overrun !== m_ovr || (m_present && fft_data !== m_front()))
        $display("FAIL simul c%0d valid=%b/%b ovr=%b/%b data=%h exp %h", c, fft_valid, m_present, overrun, m_ovr, fft_data, m_front());
      else n_pass++;
      if (fft_valid === 1'b1 && fft_ready) outs.push_back(fft_data);
      step();
    end
    nf = outs.size();
    while (outs.size() < 3) outs.push_back('0);
    f2 = outs[2];
    n_checks++;
    if (nf != 3 || overrun !== 1'b0 || f2[DW-1:0] !== 16'h3020 || f2[FW-1 -: DW] !== 16'h302F)
      $display("FAIL simul_frames count=%0d ovr=%b f2=%h..%h required 3 ovr 0 3020..302F",
               nf, overrun, f2[DW-1:0], f2[FW-1 -: DW]);
    else n_pass++;
  endtask

  task automatic test_random();
    int pv, pr;
    for (int seg = 0; seg < 6; seg++) begin
      pv = (seg % 3 == 0) ? 8 : $urandom_range(2, 7);
      pr = (seg % 3 == 1) ? 1 : $urandom_range(1, 8);
      for (int c = 0; c < 500; c++) begin
        drive($urandom_range(0, 7) < pv, DW'($urandom), $urandom_range(0, 7) < pr);
        n_checks++;
        if (fft_valid !== m_present || overrun !== m_ovr || (m_present && fft_data !== m_front()))
          $display("FAIL rand s%0d c%0d valid=%b/%b ovr=%b/%b data=%h exp %h", seg, c, fft_valid, m_present, overrun, m_ovr, fft_data, m_front());
        else n_pass++;
        step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
    test_gapped();
    test_simul_free();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
